// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv
//
// EX-stage ALU control decoder with an iterative multiply/divide unit for the
// pipelined MIPS core. The ALUop/funct decode is purely combinational. The
// mul/div unit holds the HI/LO registers. It tells the hazard unit to freeze
// IF/ID/EX when a mul/div or MFHI/MFLO instruction arrives while the unit is
// still working.
//
// Configuration macro: MULDIV_SIGNED_EN
//   Defined   - MULT and DIV are signed. The unit works on operand
//               magnitudes and applies the signs in DONE. The remainder takes
//               the sign of the dividend.
//   Undefined - MULT and DIV behave exactly like MULTU and DIVU.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   valid_i     EX stage holds a valid instruction this cycle
//   ALUop       00 lw/sw, 01 beq, 10 R-type, 11 andi
//   funct       R-type function field
//   op_a        rs operand (WIDTH bits)
//   op_b        rt operand (WIDTH bits)
//   ALUctrl     4-bit ALU control code
//   illegal_o   R-type instruction with an unsupported funct
//   stall_o     freeze IF/ID/EX this cycle
//   md_done_o   one-cycle pulse in the cycle that HI/LO are written
//   mf_valid_o  current instruction is an accepted MFHI/MFLO
//   mf_data_o   HI or LO value for MFHI/MFLO, zero otherwise
//   hi_o, lo_o  HI and LO registers

module alu_ctrl_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALUctrl,
  output logic             illegal_o,
  output logic             stall_o,
  output logic             md_done_o,
  output logic             mf_valid_o,
  output logic [WIDTH-1:0] mf_data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]   accHi_q, accHi_d;
  logic [WIDTH-1:0]   accLo_q, accLo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               isMulDiv;
  logic               isMf;
  logic               mdReq;
  logic               mfReq;
  logic               accept;
  logic               signedOp;
  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divDiff;
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodRes;
  logic [WIDTH-1:0]   quotRes;
  logic [WIDTH-1:0]   remRes;

  // The ALU control code depends only on ALUop/funct, never on the mul/div
  // state. Mul/div and move-from functs are legal R-types. They still hand
  // the ALU an add code, because the ALU result is ignored for them.
  always_comb begin
    ALUctrl   = 4'b0010;
    illegal_o = 1'b0;
    case (ALUop)
      2'b00: ALUctrl = 4'b0010;
      2'b01: ALUctrl = 4'b0110;
      2'b11: ALUctrl = 4'b0000;
      default: begin
        case (funct)
          FN_ADD:   ALUctrl = 4'b0010;
          FN_SUB:   ALUctrl = 4'b0110;
          FN_AND:   ALUctrl = 4'b0000;
          FN_OR:    ALUctrl = 4'b0001;
          FN_SLT:   ALUctrl = 4'b0111;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO:
                    ALUctrl = 4'b0010;
          default: begin
            ALUctrl   = 4'b0010;
            illegal_o = valid_i;
          end
        endcase
      end
    endcase
  end

  // Request classification and the hazard handshake. A mul/div or move-from
  // request is held off whenever the unit is not idle. This includes the
  // DONE cycle, so a waiting MFHI/MFLO issues one cycle later and reads the
  // freshly written HI/LO.
  assign isMulDiv   = (funct == FN_MULT) || (funct == FN_MULTU) ||
                      (funct == FN_DIV)  || (funct == FN_DIVU);
  assign isMf       = (funct == FN_MFHI) || (funct == FN_MFLO);
  assign mdReq      = valid_i && (ALUop == 2'b10) && isMulDiv;
  assign mfReq      = valid_i && (ALUop == 2'b10) && isMf;
  assign stall_o    = (mdReq || mfReq) && (state_q != IDLE);
  assign accept     = mdReq && (state_q == IDLE);
  assign md_done_o  = (state_q == DONE);
  assign mf_valid_o = mfReq && !stall_o;
  assign mf_data_o  = !mf_valid_o        ? '0 :
                      (funct == FN_MFHI) ? hi_q : lo_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

  // The iterative core always works on unsigned magnitudes. With signed
  // support enabled, MULT/DIV fold their operand signs away here. The signs
  // are remembered and applied again to the final result in DONE.
`ifdef MULDIV_SIGNED_EN
  assign signedOp = (funct == FN_MULT) || (funct == FN_DIV);
`else
  assign signedOp = 1'b0;
`endif
  assign negA = signedOp && op_a[WIDTH-1];
  assign negB = signedOp && op_b[WIDTH-1];
  assign magA = negA ? -op_a : op_a;
  assign magB = negB ? -op_b : op_b;

  // One iteration of each algorithm.
  // Multiply: {accHi,accLo} holds the partial product in its upper half and
  // the unconsumed multiplier bits in its lower half. Add the multiplicand
  // when the current multiplier bit is set, then shift the pair right,
  // keeping the carry.
  // Divide (restoring): shift the next dividend bit into the remainder, then
  // subtract the divisor if it fits. Each quotient bit enters accLo from the
  // right as the dividend bits leave from the left. When the divisor fits,
  // the true difference is below the divisor, so a WIDTH-bit subtraction is
  // exact even though the shifted remainder has one extra bit.
  always_comb begin
    mulSum   = accLo_q[0] ? ({1'b0, accHi_q} + {1'b0, operand_q})
                          : {1'b0, accHi_q};
    divShift = {accHi_q, accLo_q[WIDTH-1]};
    divFits  = (divShift >= {1'b0, operand_q});
    divDiff  = divShift[WIDTH-1:0] - operand_q;
    prodMag  = {accHi_q, accLo_q};
    prodRes  = negRes_q ? -prodMag : prodMag;
    quotRes  = negRes_q ? -accLo_q : accLo_q;
    remRes   = negRem_q ? -accHi_q : accHi_q;
  end

  // Next-state logic for the IDLE -> BUSY -> DONE sequence. BUSY runs one
  // step per cycle for exactly WIDTH cycles, counting down from WIDTH. The
  // step taken with the counter at 1 is the last one. DONE publishes the
  // signed and adjusted result into HI/LO at its closing edge.
  // Division by zero is special-cased. This gives a defined all-ones
  // quotient and hands the original dividend back as the remainder.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isDiv_d    = isDiv_q;
    negRes_d   = negRes_q;
    negRem_d   = negRem_q;
    divZero_d  = divZero_q;
    dividend_d = dividend_q;
    operand_d  = operand_q;
    accHi_d    = accHi_q;
    accLo_d    = accLo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = BUSY;
          cnt_d      = CNT_W'(WIDTH);
          isDiv_d    = funct[1];
          negRes_d   = negA ^ negB;
          negRem_d   = negA;
          divZero_d  = (op_b == '0);
          dividend_d = op_a;
          operand_d  = magB;
          accHi_d    = '0;
          accLo_d    = magA;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (isDiv_q) begin
          accHi_d = divFits ? divDiff : divShift[WIDTH-1:0];
          accLo_d = {accLo_q[WIDTH-2:0], divFits};
        end else begin
          accHi_d = mulSum[WIDTH:1];
          accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!isDiv_q) begin
          hi_d = prodRes[2*WIDTH-1:WIDTH];
          lo_d = prodRes[WIDTH-1:0];
        end else if (divZero_q) begin
          hi_d = dividend_q;
          lo_d = '1;
        end else begin
          hi_d = remRes;
          lo_d = quotRes;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, including HI/LO and the working registers, clears on reset.
  // Because the reset is asynchronous, asserting it mid-operation aborts the
  // operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      isDiv_q    <= 1'b0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      divZero_q  <= 1'b0;
      dividend_q <= '0;
      operand_q  <= '0;
      accHi_q    <= '0;
      accLo_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isDiv_q    <= isDiv_d;
      negRes_q   <= negRes_d;
      negRem_q   <= negRem_d;
      divZero_q  <= divZero_d;
      dividend_q <= dividend_d;
      operand_q  <= operand_d;
      accHi_q    <= accHi_d;
      accLo_q    <= accLo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv
//
// Directed bench for alu_ctrl_muldiv at WIDTH=32. It covers the ALU control
// decode, multiply/divide results and latency, the stall handshake with
// MFHI/MFLO, and asynchronous reset in the middle of an operation. The
// expected values for MULT/DIV follow MULDIV_SIGNED_EN.
//
// Ports: none (self-contained bench).

module tb_alu_ctrl_muldiv;

  localparam int WIDTH = 32;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic [1:0]       ALUop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       ALUctrl;
  logic             illegal_o;
  logic             stall_o;
  logic             md_done_o;
  logic             mf_valid_o;
  logic [WIDTH-1:0] mf_data_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  int testsRun;
  int testsFailed;

  alu_ctrl_muldiv #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ALUop      (ALUop),
    .funct      (funct),
    .op_a       (op_a),
    .op_b       (op_b),
    .ALUctrl    (ALUctrl),
    .illegal_o  (illegal_o),
    .stall_o    (stall_o),
    .md_done_o  (md_done_o),
    .mf_valid_o (mf_valid_o),
    .mf_data_o  (mf_data_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison in the bench passes through here.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [5:0] fn,
                               input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    valid_i = v;
    ALUop   = op;
    funct   = fn;
    op_a    = a;
    op_b    = b;
  endtask

  // Advance one clock; stimulus and sampling then happen well after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Wait for md_done_o, counting cycles since the caller's last step.
  task automatic waitDone(output int cycles);
    cycles = 0;
    #1;
    while (md_done_o !== 1'b1 && cycles < 200) begin
      stepCycle();
      #1;
      cycles++;
    end
  endtask

  // Issue one mul/div op, let it complete with the EX stage idle, and check
  // latency, the single done pulse and HI/LO.
  task automatic runMd(input string tag, input logic [5:0] fn,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] expHi,
                       input logic [WIDTH-1:0] expLo);
    int cycles;
    applyStimulus(1'b1, 2'b10, fn, a, b);
    #1;
    checkOutput({tag, " accept stall"}, 64'(stall_o), 64'd0);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    waitDone(cycles);
    checkOutput({tag, " done latency"}, 64'(cycles), 64'd32);
    stepCycle();
    #1;
    checkOutput({tag, " done pulse width"}, 64'(md_done_o), 64'd0);
    checkOutput({tag, " HI"}, 64'(hi_o), 64'(expHi));
    checkOutput({tag, " LO"}, 64'(lo_o), 64'(expLo));
  endtask

  // Directed test sequence.
  initial begin
    int n;
    int doneCount;
    logic [1:0]  decOp [7];
    logic [5:0]  decFn [7];
    logic [3:0]  decExp [7];

    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    #1;
    checkOutput("reset HI", 64'(hi_o), 64'd0);
    checkOutput("reset LO", 64'(lo_o), 64'd0);
    checkOutput("reset stall", 64'(stall_o), 64'd0);
    checkOutput("reset done", 64'(md_done_o), 64'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;

    decOp  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    decFn  = '{FN_SUB, FN_ADD, FN_OR, FN_SUB, FN_AND, FN_OR, FN_SLT};
    decExp = '{4'b0010, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, decOp[i], decFn[i], '0, '0);
      #1;
      checkOutput($sformatf("decode %0d ALUctrl", i), 64'(ALUctrl), 64'(decExp[i]));
      checkOutput($sformatf("decode %0d illegal", i), 64'(illegal_o), 64'd0);
    end
    applyStimulus(1'b1, 2'b10, FN_MFHI, '0, '0);
    #1;
    checkOutput("mfhi ALUctrl", 64'(ALUctrl), 64'b0010);
    checkOutput("mfhi illegal", 64'(illegal_o), 64'd0);
    stepCycle();

    // MULTU 7*6 followed immediately by a stalled MFLO.
    applyStimulus(1'b1, 2'b10, FN_MULTU, 32'd7, 32'd6);
    #1;
    checkOutput("multu accept stall", 64'(stall_o), 64'd0);
    stepCycle();
    applyStimulus(1'b1, 2'b10, FN_MFLO, '0, '0);
    n = 0;
    doneCount = 0;
    #1;
    while (stall_o === 1'b1 && n < 200) begin
      if (md_done_o === 1'b1) doneCount++;
      checkOutput("mflo no early valid", 64'(mf_valid_o), 64'd0);
      stepCycle();
      #1;
      n++;
    end
    checkOutput("mflo stall cycles", 64'(n), 64'd33);
    checkOutput("multu done pulses", 64'(doneCount), 64'd1);
    checkOutput("mflo valid", 64'(mf_valid_o), 64'd1);
    checkOutput("mflo data", 64'(mf_data_o), 64'd42);
    checkOutput("multu LO", 64'(lo_o), 64'd42);
    checkOutput("multu HI", 64'(hi_o), 64'd0);
    stepCycle();

    runMd("divu 100/7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    applyStimulus(1'b1, 2'b10, FN_MFHI, '0, '0);
    #1;
    checkOutput("mfhi data", 64'(mf_data_o), 64'd2);
    stepCycle();

    runMd("divu by zero", FN_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
`ifdef MULDIV_SIGNED_EN
    runMd("mult -6*3", FN_MULT, 32'hFFFFFFFA, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEE);
    runMd("div -7/2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
    runMd("mult -6*3", FN_MULT, 32'hFFFFFFFA, 32'd3, 32'h00000002, 32'hFFFFFFEE);
    runMd("div -7/2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
`endif
    runMd("multu big", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // ADD proceeds during BUSY; a second MULTU waits for IDLE.
    applyStimulus(1'b1, 2'b10, FN_MULTU, 32'd5, 32'd9);
    stepCycle();
    applyStimulus(1'b1, 2'b10, FN_ADD, 32'd1, 32'd2);
    #1;
    checkOutput("busy add ALUctrl", 64'(ALUctrl), 64'b0010);
    checkOutput("busy add stall", 64'(stall_o), 64'd0);
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 2'b10, FN_MULTU, 32'd12, 32'd11);
    #1;
    checkOutput("busy multu stall", 64'(stall_o), 64'd1);
    n = 0;
    while (stall_o === 1'b1 && n < 200) begin
      stepCycle();
      #1;
      n++;
    end
    checkOutput("second multu released", 64'(stall_o), 64'd0);
    checkOutput("first multu LO", 64'(lo_o), 64'd45);
    checkOutput("first multu HI", 64'(hi_o), 64'd0);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    waitDone(n);
    checkOutput("second multu latency", 64'(n), 64'd32);
    stepCycle();
    checkOutput("second multu LO", 64'(lo_o), 64'd132);
    checkOutput("second multu HI", 64'(hi_o), 64'd0);

    // Asynchronous reset at BUSY cycle 10.
    applyStimulus(1'b1, 2'b10, FN_MULTU, 32'd7, 32'd6);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    for (int i = 0; i < 9; i++) stepCycle();
    applyStimulus(1'b1, 2'b10, FN_MFLO, '0, '0);
    #1;
    checkOutput("busy mflo stall", 64'(stall_o), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort HI", 64'(hi_o), 64'd0);
    checkOutput("abort LO", 64'(lo_o), 64'd0);
    checkOutput("abort stall", 64'(stall_o), 64'd0);
    checkOutput("abort done", 64'(md_done_o), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post reset mflo valid", 64'(mf_valid_o), 64'd1);
    checkOutput("post reset mflo data", 64'(mf_data_o), 64'd0);
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (md_done_o === 1'b1) n++;
    end
    checkOutput("no done after abort", 64'(n), 64'd0);

    // Illegal funct handling.
    applyStimulus(1'b1, 2'b10, 6'b111111, '0, '0);
    #1;
    checkOutput("illegal funct flag", 64'(illegal_o), 64'd1);
    checkOutput("illegal funct ALUctrl", 64'(ALUctrl), 64'b0010);
    applyStimulus(1'b0, 2'b10, 6'b111111, '0, '0);
    #1;
    checkOutput("illegal funct invalid", 64'(illegal_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
